// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
// Takes 10-bit {channel, position} words from the serial instruction receiver,
// stores each in a per-channel shadow register, and pulses rx_reset to re-arm
// the receiver. Four servo PWM outputs share one fixed-length frame. New
// positions move from shadow to active only at a frame boundary, so a pulse
// that has started always runs to its full width.
//
// Build option: define SERVO_SLEW_EN to limit each channel's position change
// to SLEW_STEP per frame. Without it, the active position loads the shadow
// value directly.
//
// Handshake (valid/ready): instruction_ready is a level-valid from the receiver.
// A word is taken when instruction_ready is seen high in IDLE. The instruction
// bus must then hold steady until the LATCH cycle has sampled it. rx_reset is
// the receiver's acknowledge/re-arm. The level must be seen low again before
// another word is taken, so a stale level is never accepted twice. busy shows
// that a word is still being handled.
`timescale 1ns/1ps
module servo_pwm_driver #(
    parameter int TICK_DIV      = 50,
    parameter int FRAME_US      = 20000,
    parameter int MIN_US        = 1000,
    parameter int STEP_US       = 4,
    parameter int CENTER        = 128,
    parameter int RX_RST_CYCLES = 2,
    parameter int SLEW_STEP     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instruction_ready,
    input  logic [9:0] instruction,
    output logic       rx_reset,
    output logic [3:0] pwm_out,
    output logic       frame_start,
    output logic       busy,
    output logic [7:0] cmd_count
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam int RX_W  = (RX_RST_CYCLES > 1) ? $clog2(RX_RST_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [US_W-1:0]  US_LAST    = US_W'(FRAME_US - 1);
    localparam logic [RX_W-1:0]  RX_LAST    = RX_W'(RX_RST_CYCLES - 1);
    localparam logic [7:0]       CENTER_POS = 8'(CENTER);
    localparam logic [15:0]      MIN_W      = 16'(MIN_US);
    localparam logic [15:0]      STEP_W     = 16'(STEP_US);

`ifdef SERVO_SLEW_EN
    localparam logic [7:0] SLEW_LIM = 8'(SLEW_STEP);
`else
    // A full-range step makes the frame transfer a plain load of the shadow value.
    localparam logic [7:0] SLEW_LIM = 8'(SLEW_STEP) | 8'hFF;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LATCH    = 2'd1,
        CLEAR    = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    // Handshake state; left visible at the top level so checkers can bind to it.
    state_t          state, state_d;
    logic [RX_W-1:0] rst_cnt, rst_cnt_d;
    logic            rx_reset_d;
    logic            latch_en;

    logic [PRE_W-1:0] presc, presc_d;
    logic [US_W-1:0]  us_cnt, us_cnt_d;

    logic [7:0] shadow   [4];
    logic [7:0] active   [4];
    logic [7:0] active_d [4];
    logic [3:0] pwm_d;

    // Move cur toward tgt by at most SLEW_LIM without overshooting or wrapping.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        if (tgt >= cur) begin
            diff        = tgt - cur;
            step_toward = cur + ((diff > SLEW_LIM) ? SLEW_LIM : diff);
        end else begin
            diff        = cur - tgt;
            step_toward = cur - ((diff > SLEW_LIM) ? SLEW_LIM : diff);
        end
    endfunction

    // Pulse width in ticks for a position.
    function automatic logic [15:0] pulse_width(input logic [7:0] pos);
        pulse_width = MIN_W + {8'd0, pos} * STEP_W;
    endfunction

    // Handshake next state, rx_reset pulse length, and shadow-write strobe.
    always_comb begin
        state_d    = state;
        rst_cnt_d  = rst_cnt;
        rx_reset_d = 1'b0;
        latch_en   = 1'b0;
        case (state)
            IDLE: begin
                if (instruction_ready) state_d = LATCH;
            end
            LATCH: begin
                latch_en   = 1'b1;
                rx_reset_d = 1'b1;
                rst_cnt_d  = '0;
                state_d    = CLEAR;
            end
            CLEAR: begin
                if (rst_cnt == RX_LAST) begin
                    state_d = WAIT_LOW;
                end else begin
                    rx_reset_d = 1'b1;
                    rst_cnt_d  = rst_cnt + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!instruction_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake registers, including the busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rst_cnt  <= '0;
            rx_reset <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            rst_cnt  <= rst_cnt_d;
            rx_reset <= rx_reset_d;
            busy     <= (state_d != IDLE);
        end
    end

    // Shadow positions and the accepted-command counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) shadow[i] <= CENTER_POS;
            cmd_count <= 8'd0;
        end else if (latch_en) begin
            shadow[instruction[9:8]] <= instruction[7:0];
            cmd_count                <= cmd_count + 8'd1;
        end
    end

    // Next tick prescaler value and frame position in ticks.
    always_comb begin
        presc_d  = presc + 1'b1;
        us_cnt_d = us_cnt;
        if (presc == PRE_LAST) begin
            presc_d  = '0;
            us_cnt_d = (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
        end
    end

    // Active positions take the shadow values only while frame_start is high.
    // The PWM compare uses the position that is about to become active, so the
    // first tick of a frame already reflects the new width.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            active_d[i] = frame_start ? step_toward(active[i], shadow[i]) : active[i];
            pwm_d[i]    = (32'(us_cnt) < 32'(pulse_width(active_d[i])));
        end
    end

    // Timebase, frame marker, active positions and the PWM output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            us_cnt      <= '0;
            frame_start <= 1'b0;
            pwm_out     <= '0;
            for (int i = 0; i < 4; i++) active[i] <= CENTER_POS;
        end else begin
            presc       <= presc_d;
            us_cnt      <= us_cnt_d;
            frame_start <= (presc_d == '0) && (us_cnt_d == '0);
            pwm_out     <= pwm_d;
            for (int i = 0; i < 4; i++) active[i] <= active_d[i];
        end
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Bench for servo_pwm_driver with a small timebase (TICK_DIV=2, FRAME_US=400,
// MIN_US=100, STEP_US=1, RX_RST_CYCLES=2). A cycle-indexed model derived from
// the frame/handshake timing rules checks every output after each clock edge.
// Measured pulse widths and pulse lengths are also pinned against literal values.
`timescale 1ns/1ps
module tb_servo_pwm_driver;
  localparam int TICK_DIV  = 2;
  localparam int FRAME_US  = 400;
  localparam int MIN_US    = 100;
  localparam int STEP_US   = 1;
  localparam int CENTER    = 128;
  localparam int RX_RST    = 2;
  localparam int SLEW_STEP = 4;
  localparam int FRAME_CLK = TICK_DIV * FRAME_US;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instruction_ready = 1'b0;
  logic [9:0] instruction = '0;
  logic       rx_reset;
  logic [3:0] pwm_out;
  logic       frame_start;
  logic       busy;
  logic [7:0] cmd_count;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  servo_pwm_driver #(
    .TICK_DIV(TICK_DIV), .FRAME_US(FRAME_US), .MIN_US(MIN_US), .STEP_US(STEP_US),
    .CENTER(CENTER), .RX_RST_CYCLES(RX_RST), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk(clk), .reset(reset), .instruction_ready(instruction_ready),
    .instruction(instruction), .rx_reset(rx_reset), .pwm_out(pwm_out),
    .frame_start(frame_start), .busy(busy), .cmd_count(cmd_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // e = clock edges since reset release. After edge e the tick counter reads
  // (e/TICK_DIV) mod FRAME_US. A frame boundary is flagged after each multiple
  // of FRAME_CLK. Positions for frame f are taken from the shadow values as
  // they stood when frame f's marker appeared.
  int         e;
  bit         idle;
  bit         have_acc;
  int         acc_edge;
  int         cmd_m;
  logic [7:0] shadow_m [4];
  logic [7:0] active_m [4];

  function automatic logic [7:0] transfer(input logic [7:0] a, input logic [7:0] s);
`ifdef SERVO_SLEW_EN
    int d;
    d = int'(s) - int'(a);
    if (d > SLEW_STEP) d = SLEW_STEP;
    else if (d < -SLEW_STEP) d = -SLEW_STEP;
    return 8'(int'(a) + d);
`else
    return s;
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        e = 0; idle = 1; have_acc = 0; acc_edge = -100; cmd_m = 0;
        for (int i = 0; i < 4; i++) begin
          shadow_m[i] = 8'(CENTER);
          active_m[i] = 8'(CENTER);
        end
      end else begin
        e++;
        if (e > 1 && (e % FRAME_CLK) == 1)
          for (int i = 0; i < 4; i++) active_m[i] = transfer(active_m[i], shadow_m[i]);
        if (have_acc && e == acc_edge + 1) begin
          shadow_m[instruction[9:8]] = instruction[7:0];
          cmd_m = (cmd_m + 1) % 256;
        end
        if (idle) begin
          if (instruction_ready) begin
            idle = 0; have_acc = 1; acc_edge = e;
          end
        end else if (e >= acc_edge + RX_RST + 2 && !instruction_ready) begin
          idle = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        int ep;
        int wexp;
        check("frame_start", int'(frame_start), (e > 0 && (e % FRAME_CLK) == 0) ? 1 : 0);
        check("rx_reset", int'(rx_reset),
              (have_acc && e >= acc_edge + 1 && e <= acc_edge + RX_RST) ? 1 : 0);
        check("busy", int'(busy), idle ? 0 : 1);
        check("cmd_count", int'(cmd_count), cmd_m);
        for (int i = 0; i < 4; i++) begin
          wexp = MIN_US + int'(active_m[i]) * STEP_US;
          ep = (e >= 1 && (((e - 1) / TICK_DIV) % FRAME_US) < wexp) ? 1 : 0;
          check($sformatf("pwm_out[%0d]", i), int'(pwm_out[i]), ep);
        end
      end
    end
  end

  // ---------------- pulse measurement ----------------
  int hi_cnt [4];
  int last_w [4];
  int cyc = 0;
  int last_gap = 0;
  int rx_hi_total = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < 4; i++) begin hi_cnt[i] = 0; last_w[i] = 0; end
        cyc = 0;
      end else begin
        cyc++;
        if (frame_start) begin
          for (int i = 0; i < 4; i++) begin last_w[i] = hi_cnt[i]; hi_cnt[i] = 0; end
          last_gap = cyc;
          cyc = 0;
        end
        for (int i = 0; i < 4; i++) if (pwm_out[i]) hi_cnt[i]++;
        if (rx_reset) rx_hi_total++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frame();
    bit seen;
    seen = 0;
    for (int k = 0; k < 2 * FRAME_CLK + 10; k++) begin
      @(negedge clk); #1;
      if (frame_start) begin seen = 1; break; end
    end
    check("frame_start_timeout", int'(seen), 1);
  endtask

  // Present a word with ready held for `hold` (>= 2) sampled edges, then drop
  // ready and wait until the handshake is idle again. Call only when idle.
  task automatic send(input logic [1:0] ch, input logic [7:0] pos, input int hold);
    bit back;
    @(negedge clk);
    instruction = {ch, pos};
    instruction_ready = 1'b1;
    @(posedge clk); #1;
    check("rx_reset_at_accept", int'(rx_reset), 0);
    check("busy_at_accept", int'(busy), 1);
    @(posedge clk); #1;
    check("rx_reset_rise", int'(rx_reset), 1);
    for (int k = 2; k < hold; k++) @(posedge clk);
    @(negedge clk);
    check("busy_before_drop", int'(busy), 1);
    instruction_ready = 1'b0;
    back = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (!busy) begin back = 1; break; end
    end
    check("busy_return_idle", int'(back), 1);
  endtask

  // ---------------- main sequence ----------------
  int n_sent = 0;
  int rx0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_rx_reset", int'(rx_reset), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_cmd_count", int'(cmd_count), 0);
    @(negedge clk);
    reset = 1'b0;

`ifdef SERVO_SLEW_EN
    send(2'd0, 8'd140, 2);
    wait_frame();
    check("slew_f0_ch0", last_w[0], 456);
    wait_frame();
    check("slew_f1_ch0", last_w[0], 464);
    wait_frame();
    check("slew_f2_ch0", last_w[0], 472);
    wait_frame();
    check("slew_f3_ch0", last_w[0], 480);
    wait_frame();
    check("slew_f4_ch0", last_w[0], 480);
    check("slew_f4_ch1", last_w[1], 456);
`else
    // Idle frames at the centre position: 228 ticks = 456 clk.
    wait_frame();
    for (int i = 0; i < 4; i++) check($sformatf("center_w%0d", i), last_w[i], 456);
    check("idle_cmd_count", int'(cmd_count), 0);
    wait_frame();
    check("frame_gap", last_gap, FRAME_CLK);

    // Channel 1 to position 0: 100 ticks from the frame after next.
    rx0 = rx_hi_total;
    send(2'd1, 8'd0, 2); n_sent++;
    check("rx_reset_len", rx_hi_total - rx0, RX_RST);
    check("cmd_after_ch1", int'(cmd_count), n_sent);
    wait_frame();
    wait_frame();
    check("ch1_w0", last_w[1], 200);
    check("ch0_w_center", last_w[0], 456);
    check("ch3_w_center", last_w[3], 456);

    // Ready held for 50 cycles gives one accept.
    rx0 = rx_hi_total;
    send(2'd2, 8'd60, 50); n_sent++;
    check("hold50_cmd_count", int'(cmd_count), n_sent);
    check("hold50_rx_len", rx_hi_total - rx0, RX_RST);

    // Two writes to ch3 in one frame: the last one wins.
    send(2'd3, 8'd255, 2); n_sent++;
    send(2'd3, 8'd10, 2); n_sent++;
    check("cmd_after_ch3", int'(cmd_count), n_sent);
    wait_frame();
    wait_frame();
    check("ch3_last_wins", last_w[3], 220);
    check("ch2_w60", last_w[2], 320);
    check("ch1_w0_again", last_w[1], 200);

    // Write landing in the frame_start cycle waits one more frame.
    wait_frame();
    repeat (FRAME_CLK - 2) @(negedge clk);
    send(2'd0, 8'd50, 2); n_sent++;
    wait_frame();
    check("boundary_not_yet", last_w[0], 456);
    wait_frame();
    check("boundary_applied", last_w[0], 300);
    check("cmd_after_boundary", int'(cmd_count), n_sent);

    // Reset in the middle of a pulse while rx_reset is high.
    wait_frame();
    @(negedge clk);
    instruction = {2'd1, 8'd77};
    instruction_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_reset_rx_reset", int'(rx_reset), 1);
    check("pre_reset_pwm0", int'(pwm_out[0]), 1);
    reset = 1'b1;
    #1;
    check("async_reset_pwm_out", int'(pwm_out), 0);
    check("async_reset_rx_reset", int'(rx_reset), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_cmd_count", int'(cmd_count), 0);
    instruction_ready = 1'b0;
    n_sent = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_frame();
    for (int i = 0; i < 4; i++) check($sformatf("post_reset_w%0d", i), last_w[i], 456);
    check("post_reset_cmd_count", int'(cmd_count), n_sent);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0t required<2000000", $time);
    $fatal(1, "timeout");
  end
endmodule
